vga_glyph_string_writer: RTL and testbench

//  Renders a string of NUM_GLYPHS monochrome bitmaps (e.g. note letter, sharp, octave digit) into the VGA

---
 rtl/vga_glyph_string_writer.sv | 149 ++++++++++++++
 tb/tb_vga_glyph_string_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_glyph_string_writer.sv
// Streams a row of monochrome glyph bitmaps into the VGA adapter plot port, one pixel per clock,
// optionally erasing the previously drawn string first. Off-screen pixels are clipped, never wrapped.
module vga_glyph_string_writer #(
  parameter int GLYPH_W    = 12,
  parameter int GLYPH_H    = 12,
  parameter int NUM_GLYPHS = 3,
  parameter int GAP        = 0,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter int BG_COLOUR  = 0
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  start,
  input  logic                                  erase_prev,
  input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] glyph_bits,
  input  logic [X_W-1:0]                        x,
  input  logic [Y_W-1:0]                        y,
  input  logic [COLOUR_W-1:0]                   colour_in,
  output logic                                  busy,
  output logic                                  done,
  output logic [X_W-1:0]                        x_out,
  output logic [Y_W-1:0]                        y_out,
  output logic [COLOUR_W-1:0]                   colour,
  output logic                                  writeEn
);

  localparam int BITS = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int IW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int KW   = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
  localparam int RW   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int CW   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int XP   = X_W + 1;
  localparam int YP   = Y_W + 1;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;

  state_t               state, next_state;
  logic [KW-1:0]        k_cnt;
  logic [RW-1:0]        r_cnt;
  logic [CW-1:0]        c_cnt;
  logic [BITS-1:0]      bits_q;
  logic [X_W-1:0]       org_x, prev_x, base_x;
  logic [Y_W-1:0]       org_y, prev_y, base_y;
  logic [COLOUR_W-1:0]  col_q;
  logic                 prev_valid;
  logic                 accept, last_pix, scanning, in_view, pix_bit;
  logic [XP-1:0]        px;
  logic [YP-1:0]        py;
  logic [IW-1:0]        bit_idx;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_pix   = (k_cnt == KW'(NUM_GLYPHS - 1)) && (r_cnt == RW'(GLYPH_H - 1)) &&
                 (c_cnt == CW'(GLYPH_W - 1));
    scanning   = (state == ERASE) || (state == DRAW);
    case (state)
      // A start landing on the done cycle is deliberately dropped.
      IDLE: begin
        if (start && !done) begin
          accept     = 1'b1;
          next_state = (erase_prev && prev_valid) ? ERASE : DRAW;
        end
      end
      ERASE:   if (last_pix) next_state = DRAW;
      DRAW:    if (last_pix) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The extra coordinate bit keeps strings running off the right/bottom edge from wrapping on screen.
  always_comb begin
    base_x  = (state == ERASE) ? prev_x : org_x;
    base_y  = (state == ERASE) ? prev_y : org_y;
    px      = {1'b0, base_x} + XP'(int'(k_cnt) * (GLYPH_W + GAP)) + XP'(c_cnt);
    py      = {1'b0, base_y} + YP'(r_cnt);
    in_view = (px <= XP'(X_MAX)) && (py <= YP'(Y_MAX));
    bit_idx = IW'(int'(k_cnt) * GLYPH_W * GLYPH_H + (GLYPH_H - 1 - int'(r_cnt)) * GLYPH_W +
                  (GLYPH_W - 1 - int'(c_cnt)));
    pix_bit = bits_q[bit_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      k_cnt      <= '0;
      r_cnt      <= '0;
      c_cnt      <= '0;
      bits_q     <= '0;
      org_x      <= '0;
      org_y      <= '0;
      col_q      <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      writeEn    <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour     <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (state == FIN);
      if (accept) begin
        bits_q <= glyph_bits;
        org_x  <= x;
        org_y  <= y;
        col_q  <= colour_in;
        k_cnt  <= '0;
        r_cnt  <= '0;
        c_cnt  <= '0;
      end else if (scanning) begin
        // Counters wrap to zero after the last pixel, so DRAW after ERASE restarts cleanly.
        if (c_cnt == CW'(GLYPH_W - 1)) begin
          c_cnt <= '0;
          if (r_cnt == RW'(GLYPH_H - 1)) begin
            r_cnt <= '0;
            k_cnt <= (k_cnt == KW'(NUM_GLYPHS - 1)) ? '0 : k_cnt + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          c_cnt <= c_cnt + 1'b1;
        end
      end
      if (scanning) begin
        writeEn <= in_view && ((state == ERASE) || pix_bit);
        x_out   <= px[X_W-1:0];
        y_out   <= py[Y_W-1:0];
        colour  <= (state == ERASE) ? COLOUR_W'(BG_COLOUR) : col_q;
      end else begin
        writeEn <= 1'b0;
      end
      if (state == FIN) begin
        prev_x     <= org_x;
        prev_y     <= org_y;
        prev_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_glyph_string_writer.sv
// Self-checking bench: table-driven commands, hand-written corner sequences and random commands,
// each output stream compared cycle by cycle against a loop-based pixel model.
module tb_vga_glyph_string_writer;

  localparam int W = 12, H = 12, N = 3, GAP = 0;
  localparam int BITS = N * W * H;
  localparam int XMAX = 159, YMAX = 119, BG = 0;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic            erase_prev = 1'b0;
  logic [BITS-1:0] glyph_bits = '0;
  logic [7:0]      x = '0;
  logic [6:0]      y = '0;
  logic [2:0]      colour_in = '0;
  logic            busy, done, writeEn;
  logic [7:0]      x_out;
  logic [6:0]      y_out;
  logic [2:0]      colour;

  vga_glyph_string_writer #(
    .GLYPH_W(W), .GLYPH_H(H), .NUM_GLYPHS(N), .GAP(GAP), .X_W(8), .Y_W(7), .COLOUR_W(3),
    .X_MAX(XMAX), .Y_MAX(YMAX), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .erase_prev(erase_prev), .glyph_bits(glyph_bits),
    .x(x), .y(y), .colour_in(colour_in), .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .colour(colour), .writeEn(writeEn)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; int x; int y; int col; } pix_t;
  typedef struct { int x; int y; int col; bit erase; int mode; int exp_writes; int exp_done; } vec_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_prev_x = 0, m_prev_y = 0;
  bit   m_prev_valid = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: every screen pixel a glyph covers, in scan order, with its clip/plot decision.
  function automatic void model_phase(input int ox, input int oy, input bit erase, input int col,
                                      input logic [BITS-1:0] b);
    pix_t p;
    for (int k = 0; k < N; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          int gx = ox + k * (W + GAP) + c;
          int gy = oy + r;
          bit on = erase ? 1'b1 : b[k * W * H + (H - 1 - r) * W + (W - 1 - c)];
          p.we  = on && (gx <= XMAX) && (gy <= YMAX);
          p.x   = gx % 256;
          p.y   = gy % 128;
          p.col = erase ? BG : col;
          exp_q.push_back(p);
        end
  endfunction

  function automatic logic [BITS-1:0] make_bits(input int mode);
    logic [BITS-1:0] b = '0;
    for (int i = 0; i < BITS; i++)
      case (mode)
        0: b[i] = (i < W * H);
        1: b[i] = 1'b1;
        2: b[i] = 1'b0;
        default: b[i] = 1'($urandom_range(0, 1));
      endcase
    return b;
  endfunction

  task automatic applyStimulus(input int cx, input int cy, input int ccol, input bit cerase,
                               input logic [BITS-1:0] cbits);
    @(negedge clk);
    start      = 1'b1;
    x          = 8'(cx);
    y          = 7'(cy);
    colour_in  = 3'(ccol);
    erase_prev = cerase;
    glyph_bits = cbits;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one command and compares every output cycle; returns write count and the cycle done was seen.
  task automatic run_cmd(input int cx, input int cy, input int ccol, input bit cerase,
                         input logic [BITS-1:0] cbits, input bit disturb,
                         output int writes, output int done_cyc);
    int sz;
    logic [31:0] act, expv;
    exp_q.delete();
    if (cerase && m_prev_valid) model_phase(m_prev_x, m_prev_y, 1'b1, 0, cbits);
    model_phase(cx, cy, 1'b0, ccol, cbits);
    sz = exp_q.size();
    writes = 0;
    done_cyc = -1;
    applyStimulus(cx, cy, ccol, cerase, cbits);
    checkOutput("busy_c1", {31'b0, busy}, 32'd1);
    for (int n = 2; n <= sz + 2; n++) begin
      pix_t e;
      bit ewe;
      @(negedge clk);
      if (disturb && n == 50) begin
        start = 1'b1;
        glyph_bits = ~glyph_bits;
      end
      if (disturb && n == 51) start = 1'b0;
      if (disturb && n == 200) glyph_bits = make_bits(3);
      if (n - 2 < sz) e = exp_q[n - 2];
      else e = '{we: 1'b0, x: 0, y: 0, col: 0};
      ewe = e.we;
      act  = {11'b0, writeEn, writeEn ? x_out : 8'd0, writeEn ? y_out : 7'd0,
              writeEn ? colour : 3'd0, busy, done};
      expv = {11'b0, ewe, ewe ? 8'(e.x) : 8'd0, ewe ? 7'(e.y) : 7'd0, ewe ? 3'(e.col) : 3'd0,
              (n < sz + 2), (n == sz + 2)};
      checkOutput($sformatf("pix_c%0d", n), act, expv);
      if (writeEn) writes++;
      if (done && done_cyc < 0) done_cyc = n;
    end
    m_prev_x = cx;
    m_prev_y = cy;
    m_prev_valid = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    int wr, dc;
    vecs[0] = '{x: 10,  y: 20,  col: 5, erase: 1, mode: 0, exp_writes: 144, exp_done: 434};
    vecs[1] = '{x: 40,  y: 20,  col: 3, erase: 1, mode: 0, exp_writes: 576, exp_done: 866};
    vecs[2] = '{x: 150, y: 20,  col: 6, erase: 0, mode: 1, exp_writes: 120, exp_done: 434};
    vecs[3] = '{x: 150, y: 115, col: 2, erase: 1, mode: 1, exp_writes: 170, exp_done: 866};
    vecs[4] = '{x: 0,   y: 0,   col: 7, erase: 0, mode: 2, exp_writes: 0,   exp_done: 434};
    vecs[5] = '{x: 255, y: 127, col: 1, erase: 1, mode: 1, exp_writes: 432, exp_done: 866};

    repeat (3) @(negedge clk);
    checkOutput("reset_state", {12'b0, busy, done, writeEn, x_out, y_out, colour},
                32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      run_cmd(vecs[i].x, vecs[i].y, vecs[i].col, vecs[i].erase, make_bits(vecs[i].mode), 1'b0, wr, dc);
      checkOutput($sformatf("vec%0d_writes", i), 32'(wr), 32'(vecs[i].exp_writes));
      checkOutput($sformatf("vec%0d_done", i), 32'(dc), 32'(vecs[i].exp_done));
    end

    // Start while busy and glyph_bits changes mid-command must not disturb the stream.
    run_cmd(60, 50, 4, 1'b0, make_bits(3), 1'b1, wr, dc);
    checkOutput("disturb_done", 32'(dc), 32'd434);

    // A start on the done cycle is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_start_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("done_start_idle", {30'b0, busy, writeEn}, 32'd0);

    // Reset mid-draw aborts at once and forgets the previous string.
    applyStimulus(30, 40, 5, 1'b0, make_bits(1));
    repeat (100) @(negedge clk);
    checkOutput("pre_abort_we", {31'b0, writeEn}, 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("abort_async", {30'b0, busy, writeEn}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("abort_hold", {29'b0, busy, writeEn, done}, 32'd0);
    resetn = 1'b1;
    m_prev_valid = 1'b0;
    run_cmd(10, 20, 5, 1'b1, make_bits(0), 1'b0, wr, dc);
    checkOutput("post_abort_writes", 32'(wr), 32'd144);
    checkOutput("post_abort_done", 32'(dc), 32'd434);

    for (int i = 0; i < 4; i++) begin
      int rx = $urandom_range(0, 255);
      int ry = $urandom_range(0, 127);
      int rc = $urandom_range(0, 7);
      bit re = 1'($urandom_range(0, 1));
      int expd = 2 + (re ? 2 : 1) * BITS;
      run_cmd(rx, ry, rc, re, make_bits(3), 1'b0, wr, dc);
      checkOutput($sformatf("rand%0d_done", i), 32'(dc), 32'(expd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
